// File: rtl/sigma_delta_decimator_if.sv
// Bitstream-in / decimated-sample-out bundle for the sinc3 sigma-delta decimator.
interface sigma_delta_decimator_if;
   logic        bit_in;
   logic        bit_valid;
   logic [15:0] dout;
   logic        dout_valid;

   modport master (output bit_in, output bit_valid, input dout, input dout_valid);
   modport slave  (input bit_in, input bit_valid, output dout, output dout_valid);
endinterface

// File: rtl/sigma_delta_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed 16-bit samples out
// at 1/2**LOG2_DECIM of the accepted-bit rate, after a three-result warm-up.
module sigma_delta_decimator #(
   parameter int LOG2_DECIM = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sigma_delta_decimator_if.slave  sd
);
   localparam int W     = 3 * LOG2_DECIM + 2;
   localparam int SHIFT = 3 * LOG2_DECIM - 15;
   localparam logic [LOG2_DECIM-1:0] PHASE_LAST = '1;
   localparam logic signed [W-1:0]   SAT_HI = W'(32767);
   localparam logic signed [W-1:0]   SAT_LO = W'(-32768);

   typedef enum logic {WARMUP, RUN} state_t;

   function automatic logic signed [15:0] scale_sat(input logic signed [W-1:0] v);
      logic signed [W-1:0] s;
      s = v >>> SHIFT;
      if (s > SAT_HI)      return 16'sh7FFF;
      else if (s < SAT_LO) return 16'sh8000;
      else                 return s[15:0];
   endfunction

   logic signed [W-1:0]    x;
   logic signed [W-1:0]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic signed [W-1:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic signed [W-1:0]    c1, c2, c3;
   logic signed [W-1:0]    comb_q, comb_d;
   logic [LOG2_DECIM-1:0]  phase_q, phase_d;
   logic                   strobe_q, strobe_d;
   logic                   res_vld_q, res_vld_d;
   logic [1:0]             warm_q, warm_d;
   state_t                 state_q, state_d;
   logic signed [15:0]     dout_q, dout_d;
   logic                   dout_valid_q, dout_valid_d;

   assign x = sd.bit_in ? W'(1) : {W{1'b1}};

   always_comb begin
      i1_d         = i1_q;
      i2_d         = i2_q;
      i3_d         = i3_q;
      phase_d      = phase_q;
      strobe_d     = 1'b0;
      d1_d         = d1_q;
      d2_d         = d2_q;
      d3_d         = d3_q;
      c1           = '0;
      c2           = '0;
      c3           = '0;
      comb_d       = comb_q;
      res_vld_d    = 1'b0;
      warm_d       = warm_q;
      state_d      = state_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      // Integrator stage: input rate, wraps modulo 2**W.
      if (sd.bit_valid) begin
         i1_d     = i1_q + x;
         i2_d     = i2_q + i1_d;
         i3_d     = i3_q + i2_d;
         phase_d  = phase_q + 1'b1;
         strobe_d = (phase_q == PHASE_LAST);
      end

      // Comb stage: samples the third integrator as it stood before this edge.
      if (strobe_q) begin
         c1        = i3_q - d1_q;
         c2        = c1 - d2_q;
         c3        = c2 - d3_q;
         d1_d      = i3_q;
         d2_d      = c1;
         d3_d      = c2;
         comb_d    = c3;
         res_vld_d = 1'b1;
      end

      // Output stage: the first three results only fill the comb delay line.
      if (res_vld_q) begin
         if (state_q == RUN) begin
            dout_d       = scale_sat(comb_q);
            dout_valid_d = 1'b1;
         end else begin
            warm_d = warm_q + 2'd1;
            if (warm_q == 2'd2) state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1_q         <= '0;
         i2_q         <= '0;
         i3_q         <= '0;
         d1_q         <= '0;
         d2_q         <= '0;
         d3_q         <= '0;
         comb_q       <= '0;
         phase_q      <= '0;
         strobe_q     <= 1'b0;
         res_vld_q    <= 1'b0;
         warm_q       <= 2'd0;
         state_q      <= WARMUP;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         i1_q         <= i1_d;
         i2_q         <= i2_d;
         i3_q         <= i3_d;
         d1_q         <= d1_d;
         d2_q         <= d2_d;
         d3_q         <= d3_d;
         comb_q       <= comb_d;
         phase_q      <= phase_d;
         strobe_q     <= strobe_d;
         res_vld_q    <= res_vld_d;
         warm_q       <= warm_d;
         state_q      <= state_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign sd.dout       = dout_q;
   assign sd.dout_valid = dout_valid_q;
endmodule
